conv_row_sequencer: RTL and testbench

// - Layer-level controller driving the start/done protocol of input_buffer_bank and active_row_register.
// - Host-side job handshake in; prefetch start, per-row start and final sa_done out.
// - Counts arr_row_done pulses until all H-R+1 output rows are complete.
// - Sits in the conv wrapper between the host/top FSM and the IB+ARR+systolic-array datapath.

---
 rtl/conv_row_sequencer_pkg.sv | 18 +
 rtl/conv_row_sequencer.sv | 149 ++++++++++++++
 tb/tb_conv_row_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_row_sequencer_pkg.sv
// Shared widths and state encoding for the convolution row sequencer.
// The dimension constants match the cfg ports of input_buffer_bank.
package conv_row_sequencer_pkg;

    localparam int SEQ_IMG_DIM_W = 8;
    localparam int SEQ_KERNEL_W  = 4;
    localparam int SEQ_WDOG_W    = 16;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t SEQ_IDLE      = 3'd0;
    localparam seq_state_t SEQ_PREFETCH  = 3'd1;
    localparam seq_state_t SEQ_WAIT_IB   = 3'd2;
    localparam seq_state_t SEQ_ROW_START = 3'd3;
    localparam seq_state_t SEQ_ROW_RUN   = 3'd4;
    localparam seq_state_t SEQ_FINISH    = 3'd5;

endpackage

// File: rtl/conv_row_sequencer.sv
// Layer-level controller: accepts a host job, prefetches the input buffer, starts one
// output row at a time and signals completion once all H-R+1 rows have been produced.
module conv_row_sequencer
    import conv_row_sequencer_pkg::*;
#(
    parameter int IMG_DIM_W = SEQ_IMG_DIM_W,
    parameter int KERNEL_W  = SEQ_KERNEL_W,
    parameter int WDOG_W    = SEQ_WDOG_W
) (
    input  logic                 clk_i,
    input  logic                 rst_sync_n_i,
    input  logic                 job_start_i,
    input  logic [IMG_DIM_W-1:0] cfg_img_w_i,
    input  logic [IMG_DIM_W-1:0] cfg_img_h_i,
    input  logic [KERNEL_W-1:0]  cfg_kernel_r_i,
    input  logic                 ib_ready_i,
    input  logic                 arr_row_done_i,
    output logic                 seq_start_o,
    output logic                 sa_done_o,
    output logic                 busy_o,
    output logic                 job_done_o,
    output logic                 err_o,
    output logic [IMG_DIM_W-1:0] row_cnt_o
);

    localparam logic [IMG_DIM_W:0]   ONE_ROW    = (IMG_DIM_W+1)'(1);
    localparam logic [IMG_DIM_W-1:0] ROW_STEP   = IMG_DIM_W'(1);
    localparam logic [WDOG_W-1:0]    WDOG_STEP  = WDOG_W'(1);
    // Abort after 2**WDOG_W-1 stalled cycles: the count starts at 0 on entry.
    localparam logic [WDOG_W-1:0]    WDOG_LIMIT = {{(WDOG_W-1){1'b1}}, 1'b0};

    seq_state_t state_q;
    seq_state_t state_d;

    logic [IMG_DIM_W:0]   img_w_ext;
    logic [IMG_DIM_W:0]   img_h_ext;
    logic [IMG_DIM_W:0]   kernel_r_ext;
    logic [IMG_DIM_W:0]   total_rows_calc;
    logic [IMG_DIM_W:0]   total_rows_q;
    logic [IMG_DIM_W-1:0] row_cnt_inc;
    logic [WDOG_W-1:0]    wdog_q;

    logic cfg_valid;
    logic accept;
    logic reject;
    logic row_done_seen;
    logic last_row;
    logic in_wait;
    logic wdog_expired;
    logic abort;

    // Config is checked one bit wider than the image dimension so H-R+1 never wraps.
    assign img_w_ext       = {1'b0, cfg_img_w_i};
    assign img_h_ext       = {1'b0, cfg_img_h_i};
    assign kernel_r_ext    = (IMG_DIM_W+1)'(cfg_kernel_r_i);
    assign total_rows_calc = img_h_ext - kernel_r_ext + ONE_ROW;

    assign cfg_valid = (kernel_r_ext != '0)
                    && (kernel_r_ext <= img_h_ext)
                    && (kernel_r_ext <= img_w_ext);

    assign accept        = (state_q == SEQ_IDLE) && job_start_i && cfg_valid;
    assign reject        = (state_q == SEQ_IDLE) && job_start_i && !cfg_valid;
    assign row_done_seen = (state_q == SEQ_ROW_RUN) && arr_row_done_i;
    assign row_cnt_inc   = row_cnt_o + ROW_STEP;
    assign last_row      = ({1'b0, row_cnt_inc} == total_rows_q);
    assign in_wait       = (state_q == SEQ_WAIT_IB) || (state_q == SEQ_ROW_RUN);
    assign wdog_expired  = in_wait && (wdog_q == WDOG_LIMIT);

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (accept) state_d = SEQ_PREFETCH;
            end
            SEQ_PREFETCH: begin
                state_d = SEQ_WAIT_IB;
            end
            SEQ_WAIT_IB: begin
                if (ib_ready_i) begin
                    state_d = SEQ_ROW_START;
                end else if (wdog_expired) begin
                    state_d = SEQ_FINISH;
                    abort   = 1'b1;
                end
            end
            SEQ_ROW_START: begin
                state_d = SEQ_ROW_RUN;
            end
            SEQ_ROW_RUN: begin
                if (arr_row_done_i) begin
                    state_d = last_row ? SEQ_FINISH : SEQ_WAIT_IB;
                end else if (wdog_expired) begin
                    state_d = SEQ_FINISH;
                    abort   = 1'b1;
                end
            end
            SEQ_FINISH: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every one of them leaves a flop.
    // An aborted job still passes through FINISH to flush the IB, but without job_done.
    always_ff @(posedge clk_i) begin
        if (!rst_sync_n_i) begin
            state_q      <= SEQ_IDLE;
            seq_start_o  <= 1'b0;
            sa_done_o    <= 1'b0;
            busy_o       <= 1'b0;
            job_done_o   <= 1'b0;
            err_o        <= 1'b0;
            row_cnt_o    <= '0;
            total_rows_q <= '0;
            wdog_q       <= '0;
        end else begin
            state_q     <= state_d;
            seq_start_o <= (state_d == SEQ_PREFETCH) || (state_d == SEQ_ROW_START);
            busy_o      <= (state_d != SEQ_IDLE);
            sa_done_o   <= (state_d == SEQ_FINISH);
            job_done_o  <= (state_d == SEQ_FINISH) && !abort;

            if ((state_d != state_q) || !in_wait) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + WDOG_STEP;
            end

            if (accept) begin
                total_rows_q <= total_rows_calc;
                row_cnt_o    <= '0;
            end else if (row_done_seen) begin
                row_cnt_o    <= row_cnt_inc;
            end

            if (accept) begin
                err_o <= 1'b0;
            end else if (reject || abort) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Randomized self-checking bench for conv_row_sequencer: the bench plays host, IB and ARR,
// and predicts every output from the job arithmetic and the handshake it drives itself.
module tb_conv_row_sequencer;

    localparam int IMG_DIM_W = 8;
    localparam int KERNEL_W  = 4;
    localparam int WDOG_W    = 6;

    logic                 clk_i = 1'b0;
    logic                 rst_sync_n_i;
    logic                 job_start_i;
    logic [IMG_DIM_W-1:0] cfg_img_w_i;
    logic [IMG_DIM_W-1:0] cfg_img_h_i;
    logic [KERNEL_W-1:0]  cfg_kernel_r_i;
    logic                 ib_ready_i;
    logic                 arr_row_done_i;
    logic                 seq_start_o;
    logic                 sa_done_o;
    logic                 busy_o;
    logic                 job_done_o;
    logic                 err_o;
    logic [IMG_DIM_W-1:0] row_cnt_o;

    int vectors     = 0;
    int miscompares = 0;
    int model_row_cnt = 0;
    bit model_err     = 1'b0;

    always #5 clk_i = ~clk_i;

    conv_row_sequencer #(
        .IMG_DIM_W (IMG_DIM_W),
        .KERNEL_W  (KERNEL_W),
        .WDOG_W    (WDOG_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_sync_n_i   (rst_sync_n_i),
        .job_start_i    (job_start_i),
        .cfg_img_w_i    (cfg_img_w_i),
        .cfg_img_h_i    (cfg_img_h_i),
        .cfg_kernel_r_i (cfg_kernel_r_i),
        .ib_ready_i     (ib_ready_i),
        .arr_row_done_i (arr_row_done_i),
        .seq_start_o    (seq_start_o),
        .sa_done_o      (sa_done_o),
        .busy_o         (busy_o),
        .job_done_o     (job_done_o),
        .err_o          (err_o),
        .row_cnt_o      (row_cnt_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_seq_start"}, 32'(seq_start_o), 0);
        checkOutput({tag, "_sa_done"},   32'(sa_done_o),   0);
        checkOutput({tag, "_busy"},      32'(busy_o),      0);
        checkOutput({tag, "_job_done"},  32'(job_done_o),  0);
        checkOutput({tag, "_err"},       32'(err_o),       0);
        checkOutput({tag, "_row_cnt"},   32'(row_cnt_o),   0);
    endtask

    // Idle cycles with stray row_done pulses: nothing may move.
    task automatic idleGap(input int n);
        for (int i = 0; i < n; i++) begin
            arr_row_done_i = ($urandom_range(0, 2) == 0);
            ib_ready_i     = $urandom_range(0, 1) != 0;
            step();
            checkOutput("idle_busy",      32'(busy_o),      0);
            checkOutput("idle_seq_start", 32'(seq_start_o), 0);
            checkOutput("idle_sa_done",   32'(sa_done_o),   0);
            checkOutput("idle_job_done",  32'(job_done_o),  0);
            checkOutput("idle_row_cnt",   32'(row_cnt_o),   model_row_cnt);
            checkOutput("idle_err",       32'(err_o),       32'(model_err));
        end
        arr_row_done_i = 1'b0;
    endtask

    // One job: stall_after >= 0 holds ib_ready low once that many rows are done,
    // reset_row > 0 pulses reset while that row is running.
    task automatic applyStimulus(input int h, input int w, input int r, input bit second_req,
                                 input int stall_after, input int reset_row);
        int total;
        bit valid;
        int done_sent;
        bit pending;
        bit row_start_now;
        int delay;
        bit wait_ib;
        bit exp_start;
        bit fired;
        bit stalling;
        int stall_cnt;
        bit finished;
        bit exp_sa;
        bit exp_jd;
        bit exp_err;

        valid = (r != 0) && (r <= h) && (r <= w);
        total = h - r + 1;

        cfg_img_h_i    = IMG_DIM_W'(h);
        cfg_img_w_i    = IMG_DIM_W'(w);
        cfg_kernel_r_i = KERNEL_W'(r);
        job_start_i    = 1'b1;
        step();
        job_start_i    = 1'b0;

        if (!valid) begin
            model_err = 1'b1;
            checkOutput("reject_err",       32'(err_o),       1);
            checkOutput("reject_busy",      32'(busy_o),      0);
            checkOutput("reject_seq_start", 32'(seq_start_o), 0);
            for (int i = 0; i < 3; i++) begin
                step();
                checkOutput("reject_idle_start", 32'(seq_start_o), 0);
                checkOutput("reject_idle_busy",  32'(busy_o),      0);
                checkOutput("reject_row_cnt",    32'(row_cnt_o),   model_row_cnt);
            end
            return;
        end

        model_err     = 1'b0;
        model_row_cnt = 0;
        checkOutput("accept_busy",     32'(busy_o),      1);
        checkOutput("accept_err",      32'(err_o),       0);
        checkOutput("accept_row_cnt",  32'(row_cnt_o),   0);
        checkOutput("prefetch_start",  32'(seq_start_o), 1);

        done_sent     = 0;
        pending       = 1'b0;
        row_start_now = 1'b0;
        delay         = 0;
        wait_ib       = 1'b0;
        stalling      = 1'b0;
        stall_cnt     = 0;
        finished      = 1'b0;

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            fired          = 1'b0;
            arr_row_done_i = 1'b0;
            ib_ready_i     = (stall_after >= 0 && done_sent >= stall_after) ? 1'b0
                                                                            : ($urandom_range(0, 2) != 0);
            if (pending && !row_start_now) begin
                if (reset_row > 0 && done_sent == reset_row - 1) begin
                    rst_sync_n_i = 1'b0;
                    step();
                    checkAllZero("midjob_reset");
                    rst_sync_n_i  = 1'b1;
                    model_err     = 1'b0;
                    model_row_cnt = 0;
                    return;
                end
                if (delay == 0) begin
                    arr_row_done_i = 1'b1;
                    pending        = 1'b0;
                    fired          = 1'b1;
                    done_sent++;
                end else begin
                    delay--;
                end
            end else begin
                arr_row_done_i = ($urandom_range(0, 4) == 0);
            end

            job_start_i = second_req && (cyc == 7);
            if (job_start_i) begin
                cfg_img_h_i    = IMG_DIM_W'($urandom_range(1, 30));
                cfg_img_w_i    = IMG_DIM_W'($urandom_range(1, 30));
                cfg_kernel_r_i = KERNEL_W'($urandom_range(1, 5));
            end

            exp_start = wait_ib && ib_ready_i;
            step();
            job_start_i    = 1'b0;
            arr_row_done_i = 1'b0;

            if (fired && done_sent == stall_after) begin
                stalling  = 1'b1;
                stall_cnt = 0;
            end
            if (stalling) stall_cnt++;

            exp_jd  = fired && (done_sent == total);
            exp_sa  = exp_jd || (stalling && stall_cnt == 64);
            exp_err = stalling && (stall_cnt >= 64);

            checkOutput("seq_start", 32'(seq_start_o), 32'(exp_start));
            checkOutput("row_cnt",   32'(row_cnt_o),   done_sent);
            checkOutput("sa_done",   32'(sa_done_o),   32'(exp_sa));
            checkOutput("job_done",  32'(job_done_o),  32'(exp_jd));
            checkOutput("err",       32'(err_o),       32'(exp_err));
            checkOutput("busy",      32'(busy_o),      1);

            if (exp_sa) begin
                step();
                checkOutput("end_busy",     32'(busy_o),     0);
                checkOutput("end_sa_done",  32'(sa_done_o),  0);
                checkOutput("end_job_done", 32'(job_done_o), 0);
                checkOutput("end_row_cnt",  32'(row_cnt_o),  done_sent);
                checkOutput("end_err",      32'(err_o),      32'(exp_err));
                model_row_cnt = done_sent;
                model_err     = exp_err;
                finished      = 1'b1;
            end

            row_start_now = exp_start;
            if (exp_start) begin
                pending = 1'b1;
                delay   = $urandom_range(0, 4);
                wait_ib = 1'b0;
            end else if (fired || cyc == 0) begin
                wait_ib = 1'b1;
            end
        end
        checkOutput("job_completed", 32'(finished), 1);
    endtask

    initial begin
        rst_sync_n_i   = 1'b0;
        job_start_i    = 1'b0;
        cfg_img_w_i    = '0;
        cfg_img_h_i    = '0;
        cfg_kernel_r_i = '0;
        ib_ready_i     = 1'b0;
        arr_row_done_i = 1'b0;

        step();
        job_start_i = 1'b1;
        step();
        job_start_i = 1'b0;
        checkAllZero("reset");
        rst_sync_n_i = 1'b1;
        idleGap(3);

        $display("[TB] 28x28 R=5 with stray pulses and a second request");
        applyStimulus(28, 28, 5, 1'b1, -1, -1);
        idleGap(4);

        $display("[TB] H=R=5 single row");
        applyStimulus(5, 28, 5, 1'b0, -1, -1);
        idleGap(2);

        $display("[TB] invalid configs");
        applyStimulus(28, 28, 0, 1'b0, -1, -1);
        applyStimulus(5, 28, 6, 1'b0, -1, -1);
        applyStimulus(28, 8, 9, 1'b0, -1, -1);
        idleGap(2);
        applyStimulus(28, 28, 5, 1'b0, -1, -1);
        idleGap(2);

        $display("[TB] watchdog stall after row 3");
        applyStimulus(28, 28, 5, 1'b0, 3, -1);
        idleGap(3);

        $display("[TB] reset during row 10");
        applyStimulus(28, 28, 5, 1'b0, -1, 10);
        idleGap(3);
        applyStimulus(28, 28, 5, 1'b1, -1, -1);
        idleGap(2);

        $display("[TB] random jobs");
        for (int j = 0; j < 10; j++) begin
            applyStimulus($urandom_range(1, 40), $urandom_range(1, 40), $urandom_range(0, 9),
                          $urandom_range(0, 1) != 0, -1, -1);
            idleGap(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
